ysyx_22050243_icache_axi_rd: RTL and testbench

YSYX_22050243_ICACHE_AXI_RD -- requirements
Module: ysyx_22050243_icache_axi_rd

---
 rtl/ysyx_22050243_axi_pkg.sv | 23 ++
 rtl/ysyx_22050243_icache_axi_rd.sv | 141 ++++++++++++++
 tb/tb_ysyx_22050243_icache_axi_rd.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050243_axi_pkg.sv
// Shared AXI4 read-side constants and the refill FSM state type.
package ysyx_22050243_axi_pkg;

  localparam int unsigned AXI_ID_W = 4;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 64;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  // Two beats per line: AXI encodes this as len = beats - 1.
  localparam logic [7:0] LEN_2BEATS = 8'd1;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StBeat0,
    StBeat1,
    StResp,
    StDrain
  } rd_state_t;

endpackage

// File: rtl/ysyx_22050243_icache_axi_rd.sv
// Icache line refill over AXI4: one 2-beat INCR read burst per request, one result pulse.
module ysyx_22050243_icache_axi_rd
  import ysyx_22050243_axi_pkg::*;
#(
  parameter logic [AXI_ID_W-1:0] AXI_ID     = 4'd0,
  parameter int unsigned         LINE_BYTES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [63:0]         req_addr,
  input  logic                req_valid,
  output logic                res_valid,
  output logic [127:0]        res_data,
  output logic                res_err,
  output logic                ar_valid,
  input  logic                ar_ready,
  output logic [ADDR_W-1:0]   ar_addr,
  output logic [AXI_ID_W-1:0] ar_id,
  output logic [7:0]          ar_len,
  output logic [2:0]          ar_size,
  output logic [1:0]          ar_burst,
  input  logic                r_valid,
  output logic                r_ready,
  input  logic [DATA_W-1:0]   r_data,
  input  logic [1:0]          r_resp,
  input  logic                r_last,
  input  logic [AXI_ID_W-1:0] r_id
);

  localparam int unsigned OffW = $clog2(LINE_BYTES);

  rd_state_t           state_q;
  logic                ar_valid_q;
  logic                r_ready_q;
  logic                res_valid_q;
  logic                res_err_q;
  logic [127:0]        res_data_q;
  logic [ADDR_W-1:0]   ar_addr_q;
  logic [DATA_W-1:0]   beat0_q;
  logic                err_q;

  logic                beat_bad;
  logic                beat1_err;

  // Upper address bits and the in-line offset never reach the bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[63:ADDR_W], req_addr[OffW-1:0]};

  // Per-beat protocol checks, and the final error if the current beat closes a normal burst.
  always_comb begin
    beat_bad  = (r_resp != RESP_OKAY) || (r_id != AXI_ID);
    beat1_err = err_q || beat_bad || !r_last;
  end

  // Refill FSM; every bus-facing output is a register updated with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_data_q  <= '0;
      ar_addr_q   <= '0;
      beat0_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            ar_addr_q  <= {req_addr[ADDR_W-1:OffW], {OffW{1'b0}}};
            ar_valid_q <= 1'b1;
            err_q      <= 1'b0;
            state_q    <= StAddr;
          end
        end
        StAddr: begin
          if (ar_ready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= StBeat0;
          end
        end
        StBeat0: begin
          if (r_valid) begin
            beat0_q <= r_data;
            if (r_last) begin
              // Burst ended one beat short: deliver what arrived, flagged.
              err_q       <= 1'b1;
              r_ready_q   <= 1'b0;
              res_valid_q <= 1'b1;
              res_data_q  <= {{DATA_W{1'b0}}, r_data};
              res_err_q   <= 1'b1;
              state_q     <= StResp;
            end else begin
              err_q   <= err_q | beat_bad;
              state_q <= StBeat1;
            end
          end
        end
        StBeat1: begin
          if (r_valid) begin
            err_q       <= beat1_err;
            r_ready_q   <= 1'b0;
            res_valid_q <= 1'b1;
            res_data_q  <= {r_data, beat0_q};
            res_err_q   <= beat1_err;
            state_q     <= StResp;
          end
        end
        StResp: begin
          state_q <= StDrain;
        end
        StDrain: begin
          // Wait for the icache to drop its level request so it is not re-issued.
          if (!req_valid) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q    <= StIdle;
          ar_valid_q <= 1'b0;
          r_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ar_valid  = ar_valid_q;
  assign ar_addr   = ar_addr_q;
  assign ar_id     = AXI_ID;
  assign ar_len    = LEN_2BEATS;
  assign ar_size   = SIZE_8B;
  assign ar_burst  = BURST_INCR;
  assign r_ready   = r_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_ysyx_22050243_icache_axi_rd.sv
// Self-checking bench for the icache refill reader: scripted AXI slave, line-level model.
module tb_ysyx_22050243_icache_axi_rd;
  import ysyx_22050243_axi_pkg::*;

  localparam logic [3:0] TB_ID = 4'd3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  req_addr = '0;
  logic         req_valid = 1'b0;
  logic         res_valid;
  logic [127:0] res_data;
  logic         res_err;
  logic         ar_valid;
  logic         ar_ready = 1'b0;
  logic [31:0]  ar_addr;
  logic [3:0]   ar_id;
  logic [7:0]   ar_len;
  logic [2:0]   ar_size;
  logic [1:0]   ar_burst;
  logic         r_valid = 1'b0;
  logic         r_ready;
  logic [63:0]  r_data = '0;
  logic [1:0]   r_resp = '0;
  logic         r_last = 1'b0;
  logic [3:0]   r_id = '0;

  ysyx_22050243_icache_axi_rd #(
    .AXI_ID     (TB_ID),
    .LINE_BYTES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_addr  (req_addr),
    .req_valid (req_valid),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_err   (res_err),
    .ar_valid  (ar_valid),
    .ar_ready  (ar_ready),
    .ar_addr   (ar_addr),
    .ar_id     (ar_id),
    .ar_len    (ar_len),
    .ar_size   (ar_size),
    .ar_burst  (ar_burst),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_data    (r_data),
    .r_resp    (r_resp),
    .r_last    (r_last),
    .r_id      (r_id)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned ar_hs_cnt = 0;
  int unsigned exp_hs    = 0;

  // Count address handshakes as the slave sees them.
  always @(posedge clk) begin
    if (ar_valid && ar_ready) ar_hs_cnt <= ar_hs_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Junk on the read channel while the reader is not expecting a beat.
  task automatic junk_r();
    r_valid = 1'b1;
    r_data  = {$urandom, $urandom};
    r_resp  = 2'($urandom);
    r_last  = 1'($urandom);
    r_id    = 4'($urandom);
  endtask

  task automatic idle_r();
    r_valid = 1'b0;
    r_data  = {$urandom, $urandom};
  endtask

  // One refill as seen by the icache and a scripted slave; expectations come from the line rules.
  task automatic run_txn(input logic [63:0] addr, input int ar_dly, input int gap0, input int gap1,
                         input logic [63:0] d0, input logic [63:0] d1,
                         input logic [1:0] rs0, input logic [1:0] rs1,
                         input logic [3:0] id0, input logic [3:0] id1,
                         input logic last0, input logic last1, input int hold);
    logic [31:0]  exp_addr;
    logic [127:0] exp_data;
    logic         exp_err;
    int           exp_lat;
    int           lat;
    bit           seen;
    exp_addr = {addr[31:4], 4'h0};
    exp_err  = (rs0 != 2'b00) || (id0 != TB_ID) || last0;
    if (last0) begin
      exp_data = {64'h0, d0};
      exp_lat  = 3 + ar_dly + gap0;
    end else begin
      exp_data = {d1, d0};
      exp_err  = exp_err || (rs1 != 2'b00) || (id1 != TB_ID) || !last1;
      exp_lat  = 4 + ar_dly + gap0 + gap1;
    end

    req_addr  = addr;
    req_valid = 1'b1;
    lat = 0;
    @(negedge clk); lat++;
    check_eq("ar_valid_rise", 128'(ar_valid), 128'(1'b1));
    check_eq("ar_addr", 128'(ar_addr), 128'(exp_addr));
    req_addr = {$urandom, $urandom};
    for (int i = 0; i < ar_dly; i++) begin
      junk_r();
      @(negedge clk); lat++;
      check_eq("ar_valid_held", 128'(ar_valid), 128'(1'b1));
      check_eq("ar_addr_stable", 128'(ar_addr), 128'(exp_addr));
      check_eq("r_ready_in_addr", 128'(r_ready), 128'(1'b0));
    end
    idle_r();
    ar_ready = 1'b1;
    @(negedge clk); lat++;
    ar_ready = 1'b0;
    check_eq("ar_valid_drop", 128'(ar_valid), 128'(1'b0));

    for (int i = 0; i < gap0; i++) begin
      @(negedge clk); lat++;
    end
    check_eq("r_ready_beat0", 128'(r_ready), 128'(1'b1));
    r_valid = 1'b1; r_data = d0; r_resp = rs0; r_id = id0; r_last = last0;
    @(negedge clk); lat++;
    idle_r();
    if (!last0) begin
      for (int i = 0; i < gap1; i++) begin
        @(negedge clk); lat++;
      end
      check_eq("r_ready_beat1", 128'(r_ready), 128'(1'b1));
      r_valid = 1'b1; r_data = d1; r_resp = rs1; r_id = id1; r_last = last1;
      @(negedge clk); lat++;
      idle_r();
    end

    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (res_valid) seen = 1'b1;
      else begin
        @(negedge clk); lat++;
      end
    end
    check_eq("res_seen", 128'(seen), 128'(1'b1));
    check_eq("latency", 128'(lat), 128'(exp_lat));
    check_eq("res_data", res_data, exp_data);
    check_eq("res_err", 128'(res_err), 128'(exp_err));

    @(negedge clk);
    check_eq("res_pulse_single", 128'(res_valid), 128'(1'b0));
    for (int i = 0; i < hold; i++) begin
      junk_r();
      @(negedge clk);
      check_eq("no_reissue", 128'(ar_valid), 128'(1'b0));
      check_eq("r_ready_drain", 128'(r_ready), 128'(1'b0));
    end
    idle_r();
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("res_data_hold", res_data, exp_data);
    exp_hs++;
    check_eq("ar_handshakes", 128'(ar_hs_cnt), 128'(exp_hs));
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    check_eq("rst_ar_valid", 128'(ar_valid), 128'(1'b0));
    check_eq("rst_r_ready", 128'(r_ready), 128'(1'b0));
    check_eq("rst_res_valid", 128'(res_valid), 128'(1'b0));
    check_eq("rst_res_err", 128'(res_err), 128'(1'b0));
    check_eq("rst_res_data", res_data, 128'h0);
    check_eq("rst_ar_addr", 128'(ar_addr), 128'h0);
    check_eq("ar_id", 128'(ar_id), 128'(TB_ID));
    check_eq("ar_len", 128'(ar_len), 128'(8'd1));
    check_eq("ar_size", 128'(ar_size), 128'(3'b011));
    check_eq("ar_burst", 128'(ar_burst), 128'(2'b01));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Zero-wait refill.
    run_txn(64'h8000_0018, 0, 0, 0, 64'h1111, 64'h2222, 2'b00, 2'b00, TB_ID, TB_ID,
            1'b0, 1'b1, 0);
    // Address and data backpressure.
    run_txn(64'h8000_1234, 3, 2, 2, 64'hdead_beef_0000_0001, 64'hcafe_f00d_0000_0002,
            2'b00, 2'b00, TB_ID, TB_ID, 1'b0, 1'b1, 1);
    // SLVERR on beat1, then a clean refill must report no error.
    run_txn(64'h8000_0040, 0, 0, 0, 64'h3333, 64'h4444, 2'b00, 2'b10, TB_ID, TB_ID,
            1'b0, 1'b1, 0);
    run_txn(64'h8000_0050, 1, 0, 1, 64'h5555, 64'h6666, 2'b00, 2'b00, TB_ID, TB_ID,
            1'b0, 1'b1, 0);
    // Burst terminated after beat0.
    run_txn(64'h8000_0060, 0, 1, 0, 64'h7777, 64'h8888, 2'b00, 2'b00, TB_ID, TB_ID,
            1'b1, 1'b1, 0);
    // Request held high after the result.
    run_txn(64'h8000_0070, 0, 0, 0, 64'h9999, 64'haaaa, 2'b00, 2'b00, TB_ID, TB_ID,
            1'b0, 1'b1, 5);
    // Wrong ID on beat0, missing r_last on beat1.
    run_txn(64'h8000_0080, 0, 0, 0, 64'hbbbb, 64'hcccc, 2'b00, 2'b00, 4'h7, TB_ID,
            1'b0, 1'b1, 0);
    run_txn(64'h8000_0090, 0, 0, 0, 64'hdddd, 64'heeee, 2'b00, 2'b00, TB_ID, TB_ID,
            1'b0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      run_txn({$urandom, $urandom}, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)), {$urandom, $urandom}, {$urandom, $urandom},
              ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
              ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
              ($urandom_range(0, 9) == 0) ? 4'h9 : TB_ID,
              ($urandom_range(0, 9) == 0) ? 4'h9 : TB_ID,
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) != 0),
              int'($urandom_range(0, 3)));
    end

    // Reset while waiting for beat1.
    req_addr  = 64'h8000_00a0;
    req_valid = 1'b1;
    @(negedge clk);
    ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0;
    r_valid = 1'b1; r_data = 64'h1234; r_resp = 2'b00; r_id = TB_ID; r_last = 1'b0;
    @(negedge clk);
    idle_r();
    exp_hs++;
    check_eq("mid_r_ready", 128'(r_ready), 128'(1'b1));
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_ar_valid", 128'(ar_valid), 128'(1'b0));
    check_eq("mid_rst_r_ready", 128'(r_ready), 128'(1'b0));
    check_eq("mid_rst_res_valid", 128'(res_valid), 128'(1'b0));
    check_eq("mid_rst_res_data", res_data, 128'h0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("post_rst_idle", 128'(ar_valid), 128'(1'b0));
    check_eq("post_rst_no_res", 128'(res_valid), 128'(1'b0));
    run_txn(64'h8000_00b8, 1, 1, 0, 64'h0101, 64'h0202, 2'b00, 2'b00, TB_ID, TB_ID,
            1'b0, 1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
